// File: rtl/line_memory_pkg.sv
// Shared definitions for the line_memory backing store: FSM encoding, counter width,
// a clog2 helper and the OFF/IDX derived-width macros.
package line_memory_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Wide enough to hold LATENCY-1 for the full 1..15 latency range.
  localparam int LM_CNT_W = 4;

  function automatic int lm_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

`define LINE_MEMORY_OFF(lb) (line_memory_pkg::lm_clog2((lb) / 8))
`define LINE_MEMORY_IDX(d)  (line_memory_pkg::lm_clog2(d))

// File: rtl/line_memory_delay.sv
// Loadable down-counter: load a start value, count down to zero, flag terminal count at 1.
module line_memory_delay
  import line_memory_pkg::*;
#(
  parameter int CNT_W = LM_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == CNT_W'(1));

endmodule

// File: rtl/line_memory.sv
// Line-granular backing store with request/ready/complete handshake and fixed latency.
// Optional upper-address checking with an Err output: define LINE_MEMORY_ADDR_CHECK_EN.
module line_memory
  import line_memory_pkg::*;
#(
  parameter int LINE_BITS = 128,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 3
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Req,
  input  logic                   We,
  input  logic [ADDR_W-1:0]      PAddr,
  input  logic [LINE_BITS-1:0]   WData,
  input  logic [LINE_BITS/8-1:0] WStrb,
  output logic                   Ready,
  output logic [LINE_BITS-1:0]   Val,
  output logic                   En
`ifdef LINE_MEMORY_ADDR_CHECK_EN
  ,
  output logic                   Err
`endif
);

  localparam int OFF = `LINE_MEMORY_OFF(LINE_BITS);
  localparam int IDX = `LINE_MEMORY_IDX(DEPTH);
  localparam int NB  = LINE_BITS / 8;
  localparam logic [LM_CNT_W-1:0] LOAD_VAL = (LM_CNT_W)'(LATENCY - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic                 r_we;
  logic                 r_aerr;
  logic [IDX-1:0]       r_idx;
  logic [LINE_BITS-1:0] r_wdata;
  logic [NB-1:0]        r_wstrb;
  logic [LINE_BITS-1:0] r_mem [DEPTH];
  logic [LINE_BITS-1:0] w_merged;
  logic                 w_accept;
  logic                 w_tc;
  logic                 w_addr_err;
  logic                 w_acc_we;
  logic                 w_acc_err;
  logic [IDX-1:0]       w_acc_idx;
  logic                 w_rd_load;
  logic                 w_unused_addr;

  assign w_accept      = (r_state == IDLE) && Req;
  assign w_unused_addr = ^PAddr;

`ifdef LINE_MEMORY_ADDR_CHECK_EN
  assign w_addr_err = ((PAddr >> (OFF + IDX)) != '0);
`else
  assign w_addr_err = 1'b0;
`endif

  line_memory_delay #(.CNT_W(LM_CNT_W)) u_delay (
    .i_clk      (Clk),
    .i_rst_n    (Rst),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .o_tc       (w_tc)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Req) w_next = (LATENCY > 1) ? WAIT : DONE;
      WAIT:    if (w_tc) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    Ready = (r_state == IDLE);
    En    = (r_state == DONE);
`ifdef LINE_MEMORY_ADDR_CHECK_EN
    Err   = (r_state == DONE) && r_aerr;
`endif
  end

  // Request latch: control bits reset, payload does not.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_we   <= 1'b0;
      r_aerr <= 1'b0;
    end else if (w_accept) begin
      r_we   <= We;
      r_aerr <= w_addr_err;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_idx   <= PAddr[OFF+IDX-1:OFF];
      r_wdata <= WData;
      r_wstrb <= WStrb;
    end
  end

  // With LATENCY=1 DONE is entered straight from IDLE, so the read uses the live request.
  assign w_acc_we  = (r_state == IDLE) ? We : r_we;
  assign w_acc_err = (r_state == IDLE) ? w_addr_err : r_aerr;
  assign w_acc_idx = (r_state == IDLE) ? PAddr[OFF+IDX-1:OFF] : r_idx;
  assign w_rd_load = (w_next == DONE) && (r_state != DONE) && !w_acc_we && !w_acc_err;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Val <= '0;
    end else if (w_rd_load) begin
      Val <= r_mem[w_acc_idx];
    end
  end

  always_comb begin
    w_merged = r_mem[r_idx];
    for (int b = 0; b < NB; b++) begin
      if (r_wstrb[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
  end

  // Write commits on the edge leaving DONE so a following read sees it.
  always_ff @(posedge Clk) begin
    if ((r_state == DONE) && r_we && !r_aerr) begin
      r_mem[r_idx] <= w_merged;
    end
  end

endmodule
